// File: rtl/imem_prefetch_unit_pkg.sv
// Shared CPU definitions: opcode map, fetch FSM encoding and prefetch unit defaults.
package imem_prefetch_unit_pkg;

  typedef enum logic [3:0] {
    OpAdd    = 4'h0,
    OpSub    = 4'h1,
    OpAnd    = 4'h2,
    OpOr     = 4'h3,
    OpXor    = 4'h4,
    OpLoad   = 4'h5,
    OpStore  = 4'h6,
    OpBranch = 4'h7,
    OpJump   = 4'h8,
    OpHalt   = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  localparam logic [15:0] DefaultResetPc        = 16'h0000;
  localparam int unsigned DefaultFifoDepth      = 4;
  localparam int unsigned DefaultMaxOutstanding = 2;

  function automatic logic [3:0] instr_opcode(input logic [15:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; head is visible combinationally.
module fetch_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [Width-1:0]             wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [Width-1:0]             rdata,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    if (32'(ptr) == Depth - 1) return '0;
    return ptr + PtrW'(1);
  endfunction

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CntW'(Depth)) || pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/imem_prefetch_unit.sv
// Instruction prefetcher: credit-limited imem requests, in-order {pc,instr} queue to IF/ID,
// redirect drain of stale responses and a sticky halt.
module imem_prefetch_unit
  import imem_prefetch_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = DefaultFifoDepth,
  parameter int unsigned MAX_OUTSTANDING = DefaultMaxOutstanding,
  parameter logic [15:0] RESET_PC        = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        out_valid,
  output logic [15:0] out_pc,
  output logic [15:0] out_instr,
  input  logic        out_ready
);

  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AqCntW   = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e      state_q, state_d;
  logic [15:0]       fetch_pc_q, fetch_pc_d;
  logic [AqCntW-1:0] drop_cnt_q, drop_cnt_d;

  logic [FifoCntW-1:0] fifo_count;
  logic [AqCntW-1:0]   aq_count;
  logic [31:0]         fifo_head;
  logic [15:0]         aq_head;

  logic in_run, grant, retire, flush, aq_push, aq_pop, fifo_pop;

  // Outstanding requests are exactly the entries of the address queue.
  always_comb begin
    in_run   = (state_q == StRun);
    grant    = imem_req && imem_gnt;
    retire   = imem_rvalid && (aq_count != '0);
    flush    = halt || (in_run && redirect);
    aq_push  = grant && !flush;
    aq_pop   = retire && in_run && !flush;
    fifo_pop = out_valid && out_ready && !flush;
  end

  fetch_fifo #(
    .Width (32),
    .Depth (FIFO_DEPTH)
  ) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (aq_pop),
    .wdata ({aq_head, imem_rdata}),
    .pop   (fifo_pop),
    .flush (flush),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  fetch_fifo #(
    .Width (16),
    .Depth (MAX_OUTSTANDING)
  ) u_addr_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (aq_push),
    .wdata (fetch_pc_q),
    .pop   (aq_pop),
    .flush (flush),
    .rdata (aq_head),
    .count (aq_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      StRun: begin
        if (halt) begin
          drop_cnt_d = '0;
        end else if (redirect) begin
          // Count a request granted this cycle, minus a response retiring this cycle.
          fetch_pc_d = redirect_pc;
          drop_cnt_d = aq_count + AqCntW'(grant) - AqCntW'(retire);
        end else if (grant) begin
          fetch_pc_d = fetch_pc_q + 16'd1;
        end
      end
      StDrain: begin
        if (halt) begin
          drop_cnt_d = '0;
        end else begin
          if (redirect) fetch_pc_d = redirect_pc;
          if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - AqCntW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (halt) state_d = StHalted;
        else if (redirect && (drop_cnt_d != '0)) state_d = StDrain;
      end
      StDrain: begin
        if (halt) state_d = StHalted;
        else if (drop_cnt_d == '0) state_d = StRun;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_comb begin
    imem_req  = rst && in_run &&
                ((32'(fifo_count) + 32'(aq_count)) < FIFO_DEPTH) &&
                (32'(aq_count) < MAX_OUTSTANDING);
    imem_addr = fetch_pc_q;
    out_valid = rst && in_run && (fifo_count != '0);
    out_pc    = out_valid ? fifo_head[31:16] : 16'h0000;
    out_instr = out_valid ? fifo_head[15:0] : 16'h0000;
  end

endmodule

// File: tb/tb_imem_prefetch_unit.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic against
// a queue-based model of the prefetcher's observable behaviour.
module tb_imem_prefetch_unit;

  localparam logic [15:0] RstPc  = 16'h0000;
  localparam int          Depth  = 4;
  localparam int          MaxOut = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        out_ready = 1'b0;
  logic        imem_req, out_valid;
  logic [15:0] imem_addr, out_pc, out_instr;

  imem_prefetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    bit          dropped;
  } ostd_t;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = -1;
  resp_t       pend[$];
  ostd_t       m_out[$];
  logic [15:0] m_buf[$];
  logic [15:0] m_pc = RstPc;
  bit          m_halted = 1'b0;
  logic        s_req, s_valid;
  logic [15:0] s_addr, s_pc, s_instr;
  vec_t        vecs[21];

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  function automatic vec_t mk(input logic r, input logic q, input logic [15:0] a,
                              input logic v, input logic [15:0] p);
    vec_t t;
    t.ready = r; t.exp_req = q; t.exp_addr = a; t.exp_valid = v; t.exp_pc = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive imem response, check outputs at negedge, update responder and model.
  task automatic run_cycle();
    bit          rv, drain, e_req, e_valid, pop_m, g_dut;
    logic [15:0] a_dut;
    ostd_t       e;
    int          due;
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid = rv;
    if (rv) imem_rdata = mem_fn(pend[0].addr);
    else    imem_rdata = 16'($urandom);
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc; s_instr = out_instr;
    drain   = (m_out.size() > 0) && m_out[0].dropped;
    e_req   = rst && !m_halted && !drain && (m_buf.size() + m_out.size() < Depth) &&
              (m_out.size() < MaxOut);
    e_valid = rst && !m_halted && (m_buf.size() > 0);
    chk("imem_req", 16'(s_req), 16'(e_req));
    if (e_req) chk("imem_addr", s_addr, m_pc);
    chk("out_valid", 16'(s_valid), 16'(e_valid));
    if (e_valid) begin
      chk("out_pc", s_pc, m_buf[0]);
      chk("out_instr", s_instr, mem_fn(m_buf[0]));
    end
    if (!rst) begin
      chk("rst_out_pc", s_pc, 16'h0000);
      chk("rst_out_instr", s_instr, 16'h0000);
    end
    g_dut = imem_req && imem_gnt;
    a_dut = imem_addr;
    pop_m = e_valid && out_ready;
    @(posedge clk);
    if (rv) void'(pend.pop_front());
    if (g_dut && rst) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      pend.push_back('{a_dut, due});
      last_due = due;
    end
    if (!rst) begin
      m_out.delete(); m_buf.delete(); m_pc = RstPc; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (halt) begin
        m_halted = 1'b1; m_out.delete(); m_buf.delete();
      end else begin
        if (rv && m_out.size() > 0) begin
          e = m_out.pop_front();
          if (!e.dropped) m_buf.push_back(e.addr);
        end
        if (pop_m) void'(m_buf.pop_front());
        if (e_req && imem_gnt) begin
          m_out.push_back('{m_pc, 1'b0});
          m_pc = m_pc + 16'd1;
        end
        if (redirect) begin
          m_pc = redirect_pc;
          if (!drain) begin
            foreach (m_out[i]) m_out[i].dropped = 1'b1;
            m_buf.delete();
          end
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    vecs[0] = mk(1'b1, 1'b1, 16'd0, 1'b0, 16'd0);
    vecs[1] = mk(1'b1, 1'b1, 16'd1, 1'b0, 16'd0);
    for (int i = 2; i < 6; i++) vecs[i] = mk(1'b1, 1'b1, 16'(i), 1'b1, 16'(i - 2));
    vecs[6] = mk(1'b0, 1'b1, 16'd6, 1'b1, 16'd4);
    vecs[7] = mk(1'b0, 1'b1, 16'd7, 1'b1, 16'd4);
    for (int i = 8; i < 16; i++) vecs[i] = mk(1'b0, 1'b0, 16'd0, 1'b1, 16'd4);
    vecs[16] = mk(1'b1, 1'b0, 16'd0, 1'b1, 16'd4);
    for (int i = 17; i < 21; i++) vecs[i] = mk(1'b1, 1'b1, 16'(i - 9), 1'b1, 16'(i - 12));

    // Reset values, then streaming and back-pressure from the vector table.
    lat = 1; imem_gnt = 1'b1; out_ready = 1'b1;
    repeat (3) run_cycle();
    chk("reset_req", 16'(s_req), 16'd0);
    chk("reset_valid", 16'(s_valid), 16'd0);
    rst = 1'b1;
    for (int i = 0; i < 21; i++) begin
      out_ready = vecs[i].ready;
      run_cycle();
      chk($sformatf("vec%0d_req", i), 16'(s_req), 16'(vecs[i].exp_req));
      if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 16'(s_valid), 16'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
    end

    // Redirect with two requests in flight.
    lat = 3; imem_gnt = 1'b1; out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_out.size() == 2 && !m_out[0].dropped) found = 1'b1;
      else run_cycle();
    end
    chk("redir_setup", 16'(found), 16'd1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    run_cycle();
    redirect = 1'b0;
    run_cycle();
    chk("redir_valid_low", 16'(s_valid), 16'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      run_cycle();
      if (s_valid) found = 1'b1;
    end
    chk("redir_wait", 16'(found), 16'd1);
    chk("redir_first_pc", s_pc, 16'h0040);
    chk("redir_first_instr", s_instr, mem_fn(16'h0040));

    // Fetch address wrap.
    lat = 1;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    run_cycle();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      run_cycle();
      if (s_req && s_addr == 16'hFFFF) found = 1'b1;
    end
    chk("wrap_ffff_seen", 16'(found), 16'd1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      run_cycle();
      if (s_req) found = 1'b1;
    end
    chk("wrap_next_seen", 16'(found), 16'd1);
    chk("wrap_addr", s_addr, 16'h0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      imem_gnt  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      redirect  = ($urandom_range(0, 40) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                : 16'($urandom);
      lat = $urandom_range(1, 4);
      run_cycle();
    end
    redirect = 1'b0;

    // Halt with three buffered entries; redirect afterwards must not wake it.
    lat = 1; imem_gnt = 1'b1; out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_buf.size() == 3) found = 1'b1;
      else run_cycle();
    end
    chk("halt_setup", 16'(found), 16'd1);
    halt = 1'b1;
    run_cycle();
    halt = 1'b0;
    run_cycle();
    chk("halt_valid", 16'(s_valid), 16'd0);
    chk("halt_req", 16'(s_req), 16'd0);
    redirect = 1'b1; redirect_pc = 16'h0100; out_ready = 1'b1;
    run_cycle();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      chk("halted_valid", 16'(s_valid), 16'd0);
      chk("halted_req", 16'(s_req), 16'd0);
    end

    // Reset with one request outstanding; its late response must be ignored.
    rst = 1'b0;
    repeat (3) run_cycle();
    rst = 1'b1; imem_gnt = 1'b1; lat = 4;
    run_cycle();
    chk("rel_first_req", 16'(s_req), 16'd1);
    chk("rel_first_addr", s_addr, RstPc);
    imem_gnt = 1'b0;
    rst = 1'b0;
    repeat (2) run_cycle();
    rst = 1'b1;
    repeat (3) run_cycle();
    chk("stale_valid", 16'(s_valid), 16'd0);
    imem_gnt = 1'b1; lat = 1; out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle();
      if (s_valid) found = 1'b1;
    end
    chk("stale_wait", 16'(found), 16'd1);
    chk("stale_first_pc", s_pc, RstPc);
    chk("stale_first_instr", s_instr, mem_fn(RstPc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
